// File: rtl/sfm_pkg.sv
// rtl/sfm_pkg.sv - shared types and defaults for the EXPU lane arbiter
// Purpose: FP format enum/width helper, default lane latency and requester count,
//          and the tracker tag type used alongside the EXPU lane stages.
// Ports:   none (package).
package sfm_pkg;

  // Local stand-in for the FP format selector so the slice stays self-contained.
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 16;
    endcase
  endfunction

  localparam int unsigned EXPU_LANE_LATENCY = 2;
  localparam int unsigned EXPU_ARB_NUM_REQ  = 4;
  localparam int unsigned EXPU_ARB_ID_W     = $clog2(EXPU_ARB_NUM_REQ);

  typedef struct packed {
    logic                     vld;
    logic [EXPU_ARB_ID_W-1:0] id;
  } expu_tag_t;

endpackage

// File: rtl/expu_lane_arbiter_rr_grant.sv
// rtl/expu_lane_arbiter_rr_grant.sv - combinational cyclic-priority pick
// Purpose: selects the first asserted request at or after ptr_i (wrapping), only when en_i.
// Ports:   req_i     in  NUM_REQ  request vector
//          ptr_i     in  ID_W     round-robin start index (< NUM_REQ)
//          en_i      in  1        grant enable
//          gnt_o     out NUM_REQ  one-hot grant or zero
//          win_o     out ID_W     index of the granted requester (0 when none)
//          gnt_vld_o out 1        a grant was issued
module expu_rr_grant #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    win_o,
  output logic               gnt_vld_o
);

  logic [31:0]     idx;
  logic [ID_W-1:0] sel;
  logic            found;

  always_comb begin
    gnt_o     = '0;
    win_o     = '0;
    found     = 1'b0;
    idx       = '0;
    sel       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr_i is always < NUM_REQ, so one conditional subtract performs the wrap.
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      sel = idx[ID_W-1:0];
      if (en_i && !found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        win_o      = sel;
      end
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/expu_lane_arbiter.sv
// rtl/expu_lane_arbiter.sv - round-robin sequencer sharing one pipelined EXPU lane
// Purpose: issues at most one operand per cycle into the lane, tracks requester IDs through
//          LATENCY stages, routes results back, and freezes the lane on response backpressure.
// Ports:   clk_i, rst_ni                 clock, async active-low reset
//          req_valid_i/req_ready_o/req_op_i   per-requester operand handshake
//          exp_op_o, exp_en_o, exp_res_i      lane operand, lane stage enable, lane result
//          rsp_valid_o/rsp_ready_i/rsp_res_o  per-requester result handshake (shared data)
//          perf_issued_o, perf_stall_o        only with EXPU_ARB_PERF_EN defined
// Config:  EXPU_ARB_PERF_EN adds saturating grant and stall counters.
module expu_lane_arbiter
  import sfm_pkg::*;
#(
  parameter fp_format_e  FPFORMAT = FP16ALT,
  parameter int unsigned NUM_REQ  = EXPU_ARB_NUM_REQ,
  parameter int unsigned LATENCY  = EXPU_LANE_LATENCY,
  localparam int unsigned WIDTH   = fp_width(FPFORMAT)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_op_i,
  output logic [WIDTH-1:0]                exp_op_o,
  output logic                            exp_en_o,
  input  logic [WIDTH-1:0]                exp_res_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  input  logic [NUM_REQ-1:0]              rsp_ready_i,
  output logic [WIDTH-1:0]                rsp_res_o
`ifdef EXPU_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_issued_o,
  output logic [31:0]                     perf_stall_o
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  tag_t [LATENCY-1:0] trk_q, trk_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  tag_t            head;
  logic            advance;
  logic            granted;
  logic [ID_W-1:0] win;

  assign head = trk_q[LATENCY-1];

  // Bubbles at the head never hold the lane; only a real result whose owner is busy does.
  assign advance  = !head.vld || rsp_ready_i[head.id];
  assign exp_en_o = advance;

  expu_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .en_i      (advance),
    .gnt_o     (req_ready_o),
    .win_o     (win),
    .gnt_vld_o (granted)
  );

  assign exp_op_o = granted ? req_op_i[win] : '0;

  always_comb begin
    trk_d = trk_q;
    ptr_d = ptr_q;
    if (advance) begin
      trk_d[0].vld = granted;
      trk_d[0].id  = win;
      for (int k = 1; k < int'(LATENCY); k++) begin
        trk_d[k] = trk_q[k-1];
      end
    end
    if (granted) begin
      ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_q <= '0;
      ptr_q <= '0;
    end else begin
      trk_q <= trk_d;
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = head.vld && (head.id == ID_W'(i));
    end
  end

  assign rsp_res_o = head.vld ? exp_res_i : '0;

`ifdef EXPU_ARB_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (granted && (perf_issued_q != '1)) begin
      perf_issued_d = perf_issued_q + 32'd1;
    end
    if (!advance && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued_o = perf_issued_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_expu_lane_arbiter.sv
// tb/tb_expu_lane_arbiter.sv - scoreboard bench for expu_lane_arbiter with a modelled EXPU lane
module tb_expu_lane_arbiter;
  import sfm_pkg::*;

  localparam int N = 4;
  localparam int L = 2;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]        req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N-1:0][W-1:0] req_op_i;
  logic [W-1:0]        exp_op_o, exp_res_i, rsp_res_o;
  logic                exp_en_o;
`ifdef EXPU_ARB_PERF_EN
  logic [31:0]         perf_issued, perf_stall;
`endif

  expu_lane_arbiter #(
    .FPFORMAT (FP16ALT),
    .NUM_REQ  (N),
    .LATENCY  (L)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .exp_op_o    (exp_op_o),
    .exp_en_o    (exp_en_o),
    .exp_res_i   (exp_res_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_res_o   (rsp_res_o)
`ifdef EXPU_ARB_PERF_EN
    ,
    .perf_issued_o (perf_issued),
    .perf_stall_o  (perf_stall)
`endif
  );

  // Lane model: L registers that only move when the arbiter enables them.
  function automatic logic [W-1:0] lane_f(input logic [W-1:0] x);
    return (x * 16'd3) ^ 16'h1234;
  endfunction

  logic [W-1:0] lane_q [L];
  always @(posedge clk) begin
    if (exp_en_o) begin
      lane_q[0] <= exp_op_o;
      for (int k = 1; k < L; k++) lane_q[k] <= lane_q[k-1];
    end
  end
  assign exp_res_i = lane_f(lane_q[L-1]);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [W-1:0] src_q [N][$];
  logic [W-1:0] exp_q [N][$];
  int           iss_q [N][$];
  int           gnt_log[$];
  int           rsp_log[$];
  logic [N-1:0] pres;
  logic [N-1:0] rdy_hold;
  int unsigned  vld_pct = 100;
  int unsigned  rdy_pct = 100;
  bit           lat_chk = 1'b0;
  int           cyc = 0;

  function automatic bit busy();
    bit b = (pres != '0);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic clear_state();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      iss_q[i].delete();
    end
    gnt_log.delete();
    rsp_log.delete();
    pres     = '0;
    rdy_hold = '0;
    lat_chk  = 1'b0;
    vld_pct  = 100;
    rdy_pct  = 100;
  endtask

  task automatic step();
    logic [W-1:0] op_exp;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && src_q[i].size() > 0 && $urandom_range(99) < vld_pct) pres[i] = 1'b1;
      req_valid_i[i] = pres[i];
      req_op_i[i]    = pres[i] ? src_q[i][0] : '0;
      rsp_ready_i[i] = !rdy_hold[i] && ($urandom_range(99) < rdy_pct);
    end
    #1;
    check_eq("ready_onehot0", 32'($countones(req_ready_o) <= 1), 1);
    check_eq("ready_subset_valid", 32'(req_ready_o & ~req_valid_i), 0);
    check_eq("rsp_onehot0", 32'($countones(rsp_valid_o) <= 1), 1);
    check_eq("exp_en", 32'(exp_en_o), 32'(!(|(rsp_valid_o & ~rsp_ready_i))));
    check_eq("stall_no_grant", 32'(!exp_en_o && (req_ready_o != '0)), 0);
    check_eq("work_conserving", 32'(exp_en_o && (req_valid_i != '0) && (req_ready_o == '0)), 0);
    op_exp = '0;
    for (int i = 0; i < N; i++) if (req_ready_o[i]) op_exp = req_op_i[i];
    check_eq("exp_op", 32'(exp_op_o), 32'(op_exp));
    if (rsp_valid_o == '0) check_eq("rsp_res_idle", 32'(rsp_res_o), 0);
    for (int i = 0; i < N; i++) begin
      if (rsp_valid_o[i] && rsp_ready_i[i]) begin
        rsp_log.push_back(i);
        check_eq("rsp_expected", 32'(exp_q[i].size() != 0), 1);
        if (exp_q[i].size() != 0) begin
          check_eq($sformatf("rsp_data_req%0d", i), 32'(rsp_res_o), 32'(exp_q[i][0]));
          if (lat_chk) check_eq("rsp_latency", 32'(cyc - iss_q[i][0]), L);
          void'(exp_q[i].pop_front());
          void'(iss_q[i].pop_front());
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid_i[i] && req_ready_o[i]) begin
        exp_q[i].push_back(lane_f(src_q[i][0]));
        iss_q[i].push_back(cyc);
        gnt_log.push_back(i);
        void'(src_q[i].pop_front());
        pres[i] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    clear_state();
    req_valid_i = '0;
    req_op_i    = '0;
    rsp_ready_i = '1;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic drain(input string tag);
    int budget = 0;
    vld_pct  = 100;
    rdy_pct  = 100;
    rdy_hold = '0;
    while (busy() && budget < 300) begin
      step();
      budget++;
    end
    check_eq(tag, 32'(busy()), 0);
  endtask

  task automatic check_log(input string tag, input int start, input int exp_seq[$]);
    check_eq({tag, "_len"}, 32'(gnt_log.size() - start), 32'(exp_seq.size()));
    for (int k = 0; k < exp_seq.size() && (start + k) < gnt_log.size(); k++) begin
      check_eq(tag, 32'(gnt_log[start + k]), 32'(exp_seq[k]));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int gsz;
    req_valid_i = '0;
    req_op_i    = '0;
    rsp_ready_i = '1;
    clear_state();

    // Reset state: empty lane, requester 0 valid -> granted combinationally.
    #1 rst_ni = 1'b0;
    req_valid_i = 4'b0001;
    req_op_i[0] = 16'h3c00;
    #2;
    check_eq("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check_eq("rst_rsp_res", 32'(rsp_res_o), 0);
    check_eq("rst_req_ready", 32'(req_ready_o), 32'h1);
    check_eq("rst_exp_en", 32'(exp_en_o), 1);
    check_eq("rst_exp_op", 32'(exp_op_o), 32'h3c00);
    do_reset();

    // T1: single requester streams 8 ops back to back with fixed latency.
    for (int k = 0; k < 8; k++) src_q[0].push_back(W'($urandom));
    lat_chk = 1'b1;
    repeat (8) step();
    check_eq("t1_grants", 32'(gnt_log.size()), 8);
    drain("t1_drain");

    // T2: all requesters valid -> strict rotation, responses in the same order.
    do_reset();
    for (int i = 0; i < N; i++) repeat (2) src_q[i].push_back(W'($urandom));
    lat_chk = 1'b1;
    repeat (8) step();
    check_log("t2_grant_order", 0, '{0, 1, 2, 3, 0, 1, 2, 3});
    drain("t2_drain");
    check_eq("t2_rsp_len", 32'(rsp_log.size()), 8);
    for (int k = 0; k < rsp_log.size() && k < 8; k++) check_eq("t2_rsp_order", 32'(rsp_log[k]), 32'(k % N));

    // T3: head owned by requester 2 with its response port blocked -> lane frozen.
    do_reset();
    rdy_hold[2] = 1'b1;
    src_q[2].push_back(16'h4a10);
    for (int k = 0; k < 6; k++) src_q[0].push_back(W'($urandom));
    w = 0;
    while (w < 20 && !rsp_valid_o[2]) begin
      step();
      w++;
    end
    check_eq("t3_head_reached", 32'(rsp_valid_o[2]), 1);
    gsz = gnt_log.size();
    repeat (5) step();
    check_eq("t3_no_grant", 32'(gnt_log.size() - gsz), 0);
    check_eq("t3_head_held", 32'(rsp_valid_o), 32'h4);
    check_eq("t3_res_held", 32'(rsp_res_o), 32'(lane_f(16'h4a10)));
    drain("t3_drain");

    // T4: pointer at 3, requesters 1 and 3 -> 3,1,3,1 (wrap, idle 0 skipped).
    do_reset();
    src_q[2].push_back(W'($urandom));
    step();
    check_log("t4_setup", 0, '{2});
    for (int k = 0; k < 2; k++) begin
      src_q[1].push_back(W'($urandom));
      src_q[3].push_back(W'($urandom));
    end
    repeat (4) step();
    check_log("t4_grant_order", 1, '{3, 1, 3, 1});
    drain("t4_drain");

    // T5: asynchronous reset with ops in flight; no stale responses afterwards.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      src_q[0].push_back(W'($urandom));
      src_q[1].push_back(W'($urandom));
    end
    repeat (2) step();
    @(negedge clk);
    #2;
    check_eq("t5_inflight", 32'(rsp_valid_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    check_eq("t5_async_rsp_valid", 32'(rsp_valid_o), 0);
    check_eq("t5_async_rsp_res", 32'(rsp_res_o), 0);
    clear_state();
    req_valid_i = '0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].push_back(W'($urandom));
    step();
    check_log("t5_ptr_reset", 0, '{0});
    drain("t5_drain");

    // T6: random valid/ready traffic checked end to end by the scoreboard.
    do_reset();
    for (int i = 0; i < N; i++) repeat (30) src_q[i].push_back(W'($urandom));
    vld_pct = 60;
    rdy_pct = 70;
    repeat (250) step();
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
